// File: rtl/t48_xbus_port_pkg.sv
// Shared types and constants for the T48 external data-bus port.
package t48_xbus_pack;

    // Bus cycle phases.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } xbus_state_t;

    // Pad direction: 0 releases the bus, 1 drives db_o onto the pads.
    localparam logic DIR_IN  = 1'b0;
    localparam logic DIR_OUT = 1'b1;

    // Active-low strobe levels.
    localparam logic STB_ACT  = 1'b0;
    localparam logic STB_IDLE = 1'b1;

endpackage

// File: rtl/t48_xbus_port_cnt.sv
// Loadable down-counter with zero flag; stops at zero.
module t48_xbus_cnt #(
    parameter int unsigned CW = 3
) (
    input  logic          clk_i,
    input  logic          res_i,
    input  logic          en_i,
    input  logic          load_i,
    input  logic          dec_i,
    input  logic [CW-1:0] load_val_i,
    output logic          zero_o
);

    logic [CW-1:0] cnt_q;

    // Count register: load has priority over decrement; both gated by the tick enable.
    always_ff @(posedge clk_i or negedge res_i) begin
        if (!res_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            if (load_i) begin
                cnt_q <= load_val_i;
            end else if (dec_i && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/t48_xbus_port.sv
// Sequenced external data-bus cycle engine: ALE address phase, RD/WR strobe
// phase with wait states, one-tick hold, and bus direction control.
module t48_xbus_port
    import t48_xbus_pack::*;
#(
    parameter int unsigned DW           = 8,
    parameter int unsigned STROBE_TICKS = 1,
    parameter int unsigned WW           = 2
) (
    input  logic          clk_i,
    input  logic          res_i,
    input  logic          en_clk_i,
    input  logic          req_i,
    input  logic          we_i,
    input  logic [DW-1:0] addr_i,
    input  logic [DW-1:0] data_i,
    input  logic [WW-1:0] wait_i,
    input  logic          float_i,
    input  logic [DW-1:0] db_i,
    output logic [DW-1:0] db_o,
    output logic          db_dir_o,
    output logic          ale_o,
    output logic          rd_n_o,
    output logic          wr_n_o,
    output logic [DW-1:0] data_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam int unsigned CW = $clog2(STROBE_TICKS + (2 ** WW));

    xbus_state_t   state_q, state_d;
    logic          ale_q, ale_d;
    logic          rd_n_q, rd_n_d;
    logic          wr_n_q, wr_n_d;
    logic          dir_q, dir_d;
    logic [DW-1:0] db_q, db_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q;
    logic          done_q;

    logic          cnt_load;
    logic          cnt_dec;
    logic          cnt_zero;
    logic          sample;
    logic [CW-1:0] cnt_load_val;

    // Strobe length minus one; the counter is loaded directly from wait_i on the
    // accepting edge, so wait_i needs no separate holding register.
    assign cnt_load_val = CW'(STROBE_TICKS - 1) + CW'(wait_i);

    t48_xbus_cnt #(
        .CW (CW)
    ) u_cnt (
        .clk_i      (clk_i),
        .res_i      (res_i),
        .en_i       (en_clk_i),
        .load_i     (cnt_load),
        .dec_i      (cnt_dec),
        .load_val_i (cnt_load_val),
        .zero_o     (cnt_zero)
    );

    // Next-state and next-output decode; outputs are registered from these.
    always_comb begin
        state_d  = state_q;
        ale_d    = ale_q;
        rd_n_d   = rd_n_q;
        wr_n_d   = wr_n_q;
        dir_d    = dir_q;
        db_d     = db_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        sample   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    state_d  = ADDR;
                    we_d     = we_i;
                    wdata_d  = data_i;
                    cnt_load = 1'b1;
                    ale_d    = 1'b1;
                    db_d     = addr_i;
                    dir_d    = DIR_OUT;
                end
            end
            ADDR: begin
                state_d = STROBE;
                ale_d   = 1'b0;
                if (we_q) begin
                    db_d   = wdata_q;
                    dir_d  = DIR_OUT;
                    wr_n_d = STB_ACT;
                end else begin
                    dir_d  = DIR_IN;
                    rd_n_d = STB_ACT;
                end
            end
            STROBE: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    state_d = HOLD;
                    rd_n_d  = STB_IDLE;
                    wr_n_d  = STB_IDLE;
                    sample  = ~we_q;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, output and latched-request registers; frozen when en_clk_i is low.
    always_ff @(posedge clk_i or negedge res_i) begin
        if (!res_i) begin
            state_q <= IDLE;
            ale_q   <= 1'b0;
            rd_n_q  <= STB_IDLE;
            wr_n_q  <= STB_IDLE;
            dir_q   <= DIR_IN;
            db_q    <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else if (en_clk_i) begin
            state_q <= state_d;
            ale_q   <= ale_d;
            rd_n_q  <= rd_n_d;
            wr_n_q  <= wr_n_d;
            dir_q   <= dir_d;
            db_q    <= db_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            if (sample) begin
                rdata_q <= db_i;
            end
        end
    end

    // Completion pulse: updates every clock so it is one clk_i wide whatever en_clk_i does next.
    always_ff @(posedge clk_i or negedge res_i) begin
        if (!res_i) begin
            done_q <= 1'b0;
        end else begin
            done_q <= en_clk_i && (state_q == HOLD);
        end
    end

    assign db_o     = db_q;
    assign db_dir_o = ((state_q == IDLE) && float_i) ? DIR_IN : dir_q;
    assign ale_o    = ale_q;
    assign rd_n_o   = rd_n_q;
    assign wr_n_o   = wr_n_q;
    assign data_o   = rdata_q;
    assign busy_o   = (state_q != IDLE);
    assign done_o   = done_q;

endmodule

// File: tb/tb_t48_xbus_port.sv
// Self-checking bench for t48_xbus_port: default configuration and a
// DW=12 / STROBE_TICKS=2 / WW=3 configuration, against a phase-queue model.
module tb_t48_xbus_port;

    localparam int unsigned P_IDLE   = 0;
    localparam int unsigned P_ADDR   = 1;
    localparam int unsigned P_STROBE = 2;
    localparam int unsigned P_HOLD   = 3;

    logic        clk = 1'b0;
    logic        res_i;
    logic        sel;
    logic        en, req, we, flt;
    logic [11:0] addr, wdat, dbi;
    logic [2:0]  wt;

    logic [7:0]  db_o0, data_o0;
    logic        dir0, ale0, rdn0, wrn0, busy0, done0;
    logic [11:0] db_o1, data_o1;
    logic        dir1, ale1, rdn1, wrn1, busy1, done1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // reference model state
    int unsigned phq[$];
    logic        m_we;
    logic [11:0] m_data;
    logic [11:0] exp_db, exp_rd;
    logic        exp_done;
    logic        last_out;

    // observed-event counters for directed sequences
    int unsigned ale_cnt, stb_cnt, done_cnt;

    always #5 clk = ~clk;

    t48_xbus_port u_dut0 (
        .clk_i    (clk),
        .res_i    (res_i),
        .en_clk_i (en),
        .req_i    (req & ~sel),
        .we_i     (we),
        .addr_i   (addr[7:0]),
        .data_i   (wdat[7:0]),
        .wait_i   (wt[1:0]),
        .float_i  (flt),
        .db_i     (dbi[7:0]),
        .db_o     (db_o0),
        .db_dir_o (dir0),
        .ale_o    (ale0),
        .rd_n_o   (rdn0),
        .wr_n_o   (wrn0),
        .data_o   (data_o0),
        .busy_o   (busy0),
        .done_o   (done0)
    );

    t48_xbus_port #(
        .DW           (12),
        .STROBE_TICKS (2),
        .WW           (3)
    ) u_dut1 (
        .clk_i    (clk),
        .res_i    (res_i),
        .en_clk_i (en),
        .req_i    (req & sel),
        .we_i     (we),
        .addr_i   (addr),
        .data_i   (wdat),
        .wait_i   (wt),
        .float_i  (flt),
        .db_i     (dbi),
        .db_o     (db_o1),
        .db_dir_o (dir1),
        .ale_o    (ale1),
        .rd_n_o   (rdn1),
        .wr_n_o   (wrn1),
        .data_o   (data_o1),
        .busy_o   (busy1),
        .done_o   (done1)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [11:0] dmask();
        return sel ? 12'hFFF : 12'h0FF;
    endfunction

    task automatic model_reset();
        phq.delete();
        m_we     = 1'b0;
        m_data   = '0;
        exp_db   = '0;
        exp_rd   = '0;
        exp_done = 1'b0;
        last_out = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs present before the edge.
    task automatic model_step();
        int unsigned p;
        int unsigned st;
        int unsigned ws;
        exp_done = 1'b0;
        if (!en) return;
        if (phq.size() == 0) begin
            if (req) begin
                st     = sel ? 2 : 1;
                ws     = sel ? int'(wt) : int'(wt[1:0]);
                m_we   = we;
                m_data = wdat & dmask();
                exp_db = addr & dmask();
                phq.push_back(P_ADDR);
                for (int unsigned i = 0; i < st + ws; i++) phq.push_back(P_STROBE);
                phq.push_back(P_HOLD);
            end
        end else begin
            p = phq.pop_front();
            if (p == P_ADDR && m_we) exp_db = m_data;
            if (p == P_STROBE && phq.size() > 0 && phq[0] == P_HOLD && !m_we)
                exp_rd = dbi & dmask();
            if (p == P_HOLD) begin
                exp_done = 1'b1;
                last_out = m_we;
            end
        end
    endtask

    task automatic check_all();
        int unsigned fr;
        logic [11:0] o_db, o_rd;
        logic o_dir, o_ale, o_rdn, o_wrn, o_busy, o_done, e_dir;
        fr     = (phq.size() == 0) ? P_IDLE : phq[0];
        o_db   = sel ? db_o1   : {4'h0, db_o0};
        o_rd   = sel ? data_o1 : {4'h0, data_o0};
        o_dir  = sel ? dir1  : dir0;
        o_ale  = sel ? ale1  : ale0;
        o_rdn  = sel ? rdn1  : rdn0;
        o_wrn  = sel ? wrn1  : wrn0;
        o_busy = sel ? busy1 : busy0;
        o_done = sel ? done1 : done0;
        if (fr == P_IDLE)      e_dir = flt ? 1'b0 : last_out;
        else if (fr == P_ADDR) e_dir = 1'b1;
        else                   e_dir = m_we;
        chk_eq("busy",   o_busy, fr != P_IDLE);
        chk_eq("ale",    o_ale,  fr == P_ADDR);
        chk_eq("rd_n",   o_rdn,  !(fr == P_STROBE && !m_we));
        chk_eq("wr_n",   o_wrn,  !(fr == P_STROBE && m_we));
        chk_eq("db_dir", o_dir,  e_dir);
        chk_eq("db_o",   o_db,   exp_db);
        chk_eq("data_o", o_rd,   exp_rd);
        chk_eq("done",   o_done, exp_done);
        if (o_ale) ale_cnt++;
        if (!o_rdn || !o_wrn) stb_cnt++;
        if (o_done) done_cnt++;
    endtask

    task automatic clr_cnt();
        ale_cnt  = 0;
        stb_cnt  = 0;
        done_cnt = 0;
    endtask

    task automatic cyc(input logic r, input logic w, input logic [11:0] a, input logic [11:0] d,
                       input logic [2:0] ws, input logic f, input logic [11:0] b, input logic e);
        req = r; we = w; addr = a; wdat = d; wt = ws; flt = f; dbi = b; en = e;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic cyc_rand();
        cyc($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 12'($urandom), 12'($urandom),
            3'($urandom), $urandom_range(0, 4) == 0, 12'($urandom), $urandom_range(0, 9) < 7);
    endtask

    task automatic do_reset();
        res_i = 1'b0;
        req = 1'b0; we = 1'b0; en = 1'b0; flt = 1'b0;
        addr = '0; wdat = '0; dbi = '0; wt = '0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        @(negedge clk);
        res_i = 1'b1;
    endtask

    initial begin
        sel = 1'b0;
        clr_cnt();
        @(negedge clk);
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 1);

        // write 0x3C / 0xA5, no wait states
        clr_cnt();
        cyc(1, 1, 12'h03C, 12'h0A5, 0, 0, 0, 1);
        repeat (4) cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk_eq("wr_ale_cycles", ale_cnt, 1);
        chk_eq("wr_strobe_cycles", stb_cnt, 1);
        chk_eq("wr_done_pulses", done_cnt, 1);
        chk_eq("wr_idle_dir", dir0, 1'b1);

        // read with 3 wait states
        clr_cnt();
        cyc(1, 0, 12'h012, 0, 3, 0, 12'h05A, 1);
        repeat (7) cyc(0, 0, 0, 0, 0, 0, 12'h05A, 1);
        chk_eq("rd_strobe_cycles", stb_cnt, 4);
        chk_eq("rd_done_pulses", done_cnt, 1);
        chk_eq("rd_data", data_o0, 8'h5A);

        // machine tick every third clock, read with 1 wait state
        clr_cnt();
        for (int i = 0; i < 15; i++)
            cyc(i == 0, 0, 12'h021, 0, 1, 0, 12'h066, (i % 3) == 0);
        chk_eq("slow_ale_cycles", ale_cnt, 3);
        chk_eq("slow_strobe_cycles", stb_cnt, 6);
        chk_eq("slow_done_pulses", done_cnt, 1);

        // request held high across busy writes
        clr_cnt();
        for (int i = 0; i < 10; i++)
            cyc(1, 1, 12'($urandom), 12'($urandom), 0, 0, 0, 1);
        chk_eq("held_req_accepts", ale_cnt, 3);
        chk_eq("held_req_done", done_cnt, 2);

        // reset in the middle of a write strobe
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 12'h055, 12'h0C3, 2, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk_eq("pre_reset_wr_n", wrn0, 1'b0);
        @(posedge clk);
        #1 res_i = 1'b0;
        #1;
        chk_eq("rst_wr_n", wrn0, 1'b1);
        chk_eq("rst_dir", dir0, 1'b0);
        chk_eq("rst_db_o", db_o0, 8'h00);
        chk_eq("rst_busy", busy0, 1'b0);
        model_reset();
        @(negedge clk);
        res_i = 1'b1;

        for (int i = 0; i < 400; i++) cyc_rand();

        // wide configuration
        sel = 1'b1;
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        clr_cnt();
        cyc(1, 0, 12'h3F0, 0, 7, 0, 12'hABC, 1);
        repeat (12) cyc(0, 0, 0, 0, 0, 0, 12'hABC, 1);
        chk_eq("wide_strobe_cycles", stb_cnt, 9);
        chk_eq("wide_rd_data", data_o1, 12'hABC);
        cyc(1, 1, 12'h123, 12'h456, 0, 0, 0, 1);
        repeat (5) cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk_eq("wide_post_write_dir", dir1, 1'b1);
        cyc(0, 0, 0, 0, 0, 1, 0, 1);
        chk_eq("wide_float_dir", dir1, 1'b0);

        for (int i = 0; i < 300; i++) cyc_rand();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/t48_xbus_port.md
# t48_xbus_port

Parametrised external data-bus port for the T48 core family. It generalises the DB bus latch into a sequenced external-memory cycle engine: address phase with ALE, data phase with RD/WR strobes, programmable wait states, bus-direction control and input sampling. It sits between the T48 decoder/ALU data path and the pad-level DB bus, and is shared by MOVX, INS and OUTL style accesses.

## Interface
- DW, 8, data/address bus width in bits (≥4).
- STROBE_TICKS, 1, minimum RD/WR strobe length in en_clk_i ticks (≥1).
- WW, 2, width of the per-access wait-state field.
- clk_i  in  1  system clock; all state on rising edge.
- res_i  in  1  reset; one clock; reset is asynchronous and active-low.
- en_clk_i  in  1  machine-tick enable; state advances only on clk_i edges with en_clk_i=1.
- req_i  in  1  access request; sampled in IDLE on a tick.
- we_i  in  1  1=write cycle, 0=read cycle; sampled with req_i.
- addr_i  in  DW  address driven during ALE phase.
- data_i  in  DW  write data.
- wait_i  in  WW  extra strobe ticks for this access.
- float_i  in  1  1: release bus (db_dir_o=0) while IDLE.
- db_i  in  DW  pad input bus.
- db_o  out  DW  pad output bus.
- db_dir_o  out  1  1=drive db_o onto pads.
- ale_o  out  1  address latch enable, active high.
- rd_n_o  out  1  read strobe, active low.
- wr_n_o  out  1  write strobe, active low.
- data_o  out  DW  last sampled read data (registered).
- busy_o  out  1  1 whenever state ≠ IDLE.
- done_o  out  1  one-clk_i pulse at cycle completion.

## Operation
- States: IDLE, ADDR, STROBE, HOLD. All transitions require en_clk_i=1; en_clk_i=0 freezes every register.
- IDLE: on req_i, latch addr_i, data_i, we_i, wait_i into internal regs; load counter with STROBE_TICKS+wait_i−1; → ADDR. req_i outside IDLE is ignored (no queuing).
- ADDR (exactly 1 tick): ale_o=1, db_o=latched addr, db_dir_o=1, strobes high. → STROBE.
- STROBE: write: db_o=latched data, db_dir_o=1, wr_n_o=0. Read: db_dir_o=0, rd_n_o=0. Counter decrements each tick; at counter=0 tick: read samples db_i into data_o; → HOLD.
- HOLD (exactly 1 tick): strobes high; write keeps db_o=data, db_dir_o=1 (data hold time); read keeps db_dir_o=0. → IDLE, done_o=1 for that clk_i cycle.
- IDLE outputs: db_o = last driven value; db_dir_o = 0 if float_i=1 or last access was a read, else holds 1 (post-write bus retention, as the DB latch does).
- Counter width: clog2(STROBE_TICKS + 2^WW); no overflow possible. wait_i=0 gives strobe of exactly STROBE_TICKS ticks.
- data_o changes only at a read sample tick; write cycles never disturb it.

## Timing
- Reset (res_i=0, async): state=IDLE, db_o=0, db_dir_o=0, ale_o=0, rd_n_o=1, wr_n_o=1, data_o=0, busy_o=0, done_o=0, latched regs=0. Reset mid-cycle aborts immediately; strobes deassert asynchronously.
- Access length in ticks: 1 (ADDR) + STROBE_TICKS + wait_i + 1 (HOLD). Default params, wait_i=0: 3 ticks.
- Accepting req_i: busy_o rises on the accepting edge; earliest next acceptance is the tick after the HOLD→IDLE edge (back-to-back with one IDLE tick).
- done_o is combinationally decoupled: registered, high for one clk_i cycle following the HOLD→IDLE edge, regardless of en_clk_i on that next cycle.
- Read data valid on data_o the clk_i cycle after the last STROBE tick, before done_o.
- float_i acts combinationally on db_dir_o only in IDLE.

## Structure
- Shared package t48_xbus_pack: state enum (IDLE/ADDR/STROBE/HOLD), bus-direction constants (DIR_IN=0, DIR_OUT=1), strobe-level constants.
- One natural sub-module: t48_xbus_cnt, loadable down-counter with zero flag, parametrised width.
- Everything else in one module; all outputs from registers except db_dir_o IDLE gating.

## Test plan
- Reset: assert res_i=0 mid-STROBE of a write → same cycle wr_n_o=1, db_dir_o=0, db_o=0, busy_o=0.
- Write DW=8, addr 0x3C, data 0xA5, wait_i=0, en_clk_i=1 every cycle → ale_o high 1 cycle with db_o=0x3C; wr_n_o low 1 cycle with db_o=0xA5; done_o pulse; db_dir_o stays 1 in IDLE with float_i=0.
- Read, wait_i=3, db_i=0x5A → rd_n_o low 4 ticks, db_dir_o=0 throughout STROBE/HOLD, data_o=0x5A before done_o.
- en_clk_i asserted every 3rd clk_i, read with wait_i=1 → all phases stretched ×3, strobe low 6 clk_i, done_o still exactly 1 clk_i wide.
- req_i held high during a busy write → exactly one access per request window; second accepted only after one IDLE tick.
- DW=12, STROBE_TICKS=2, WW=3, wait_i=7, read 0xABC → strobe 9 ticks, data_o=0xABC; float_i=1 after a write forces db_dir_o=0.
